// File: rtl/time_adjust_ctrl.sv
// Mode controller for a clock/alarm: runs timekeeping, steps through the four
// adjustable fields, times out idle adjustment and rings/auto-silences the alarm.
module time_adjust_ctrl #(
    parameter int TIMEOUT_TICKS = 30,
    parameter int ALARM_TICKS   = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_c,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       sec_wrap,
    input  logic       min_wrap,
    input  logic       alarm_match,
    output logic       sec_en,
    output logic       tmin_en,
    output logic       thr_en,
    output logic       amin_en,
    output logic       ahr_en,
    output logic       up_down,
    output logic [1:0] sel,
    output logic       set_mode,
    output logic       blink,
    output logic       alarm_ring
);

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_SET_THR  = 3'd1,
        S_SET_TMIN = 3'd2,
        S_SET_AHR  = 3'd3,
        S_SET_AMIN = 3'd4
    } state_t;

    localparam logic [6:0] IDLE_LAST = 7'(TIMEOUT_TICKS - 1);
    localparam logic [6:0] RING_LAST = 7'(ALARM_TICKS - 1);

    state_t     r_state;
    state_t     w_next;
    state_t     w_fwd;
    state_t     w_back;
    logic [6:0] r_idle;
    logic [6:0] r_ring_cnt;
    logic       r_ring;
    logic       r_match_d;
    logic       r_blink;
    logic [1:0] r_sel;
    logic       r_set_mode;

    logic       w_any_btn;
    logic       w_in_set;
    logic       w_center;
    logic       w_move;
    logic       w_adj;
    logic       w_timeout;
    logic       w_ring_done;
    logic       w_rise;
    logic       w_entry;

    // While ringing, every button is swallowed to silence the alarm.
    assign w_any_btn   = btn_c | btn_l | btn_r | btn_u | btn_d;
    assign w_in_set    = (r_state != S_RUN);
    assign w_center    = btn_c & ~r_ring;
    assign w_move      = ~r_ring & ~btn_c & (btn_l ^ btn_r);
    assign w_adj       = ~r_ring & ~btn_c & ~btn_l & ~btn_r & (btn_u ^ btn_d);
    assign w_timeout   = w_in_set & tick_1hz & ~w_any_btn & (r_idle == IDLE_LAST);
    assign w_ring_done = r_ring & tick_1hz & (r_ring_cnt == RING_LAST);
    assign w_rise      = alarm_match & ~r_match_d;
    assign w_entry     = (w_next != r_state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_fwd  = S_RUN;
        w_back = S_RUN;
        case (r_state)
            S_SET_THR:  begin w_fwd = S_SET_TMIN; w_back = S_SET_AMIN; end
            S_SET_TMIN: begin w_fwd = S_SET_AHR;  w_back = S_SET_THR;  end
            S_SET_AHR:  begin w_fwd = S_SET_AMIN; w_back = S_SET_TMIN; end
            S_SET_AMIN: begin w_fwd = S_SET_THR;  w_back = S_SET_AHR;  end
            default:    begin w_fwd = S_RUN;      w_back = S_RUN;      end
        endcase
    end

    always_comb begin
        w_next = r_state;
        if (!w_in_set) begin
            if (w_center) begin
                w_next = S_SET_THR;
            end
        end else if (w_center) begin
            w_next = S_RUN;
        end else if (w_move) begin
            w_next = btn_r ? w_fwd : w_back;
        end else if (w_timeout) begin
            w_next = S_RUN;
        end
    end

    // Enables are zero-latency so a button press moves the counter in the same cycle.
    always_comb begin
        sec_en  = 1'b0;
        tmin_en = 1'b0;
        thr_en  = 1'b0;
        amin_en = 1'b0;
        ahr_en  = 1'b0;
        up_down = 1'b0;
        if (!rst) begin
            if (!w_in_set) begin
                sec_en  = tick_1hz;
                tmin_en = tick_1hz & sec_wrap;
                thr_en  = tick_1hz & sec_wrap & min_wrap;
            end else if (w_adj) begin
                up_down = btn_d;
                case (r_state)
                    S_SET_THR:  thr_en  = 1'b1;
                    S_SET_TMIN: tmin_en = 1'b1;
                    S_SET_AHR:  ahr_en  = 1'b1;
                    S_SET_AMIN: amin_en = 1'b1;
                    default:    up_down = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= 7'd0;
        end else if (w_next == S_RUN || w_entry || w_any_btn) begin
            r_idle <= 7'd0;
        end else if (tick_1hz) begin
            r_idle <= r_idle + 7'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink <= 1'b0;
        end else if (w_next == S_RUN || w_entry) begin
            r_blink <= 1'b0;
        end else if (tick_1hz) begin
            r_blink <= ~r_blink;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match_d  <= 1'b0;
            r_ring     <= 1'b0;
            r_ring_cnt <= 7'd0;
        end else begin
            r_match_d <= alarm_match;
            if (r_ring && (w_any_btn || w_ring_done)) begin
                r_ring <= 1'b0;
            end else if (!w_in_set && w_rise) begin
                r_ring <= 1'b1;
            end
            if (!r_ring || w_any_btn || w_ring_done) begin
                r_ring_cnt <= 7'd0;
            end else if (tick_1hz) begin
                r_ring_cnt <= r_ring_cnt + 7'd1;
            end
        end
    end

    // sel/set_mode are decoded from the next state so they line up with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel      <= 2'd0;
            r_set_mode <= 1'b0;
        end else begin
            r_set_mode <= (w_next != S_RUN);
            case (w_next)
                S_SET_TMIN: r_sel <= 2'd1;
                S_SET_AHR:  r_sel <= 2'd2;
                S_SET_AMIN: r_sel <= 2'd3;
                default:    r_sel <= 2'd0;
            endcase
        end
    end

    assign sel        = r_sel;
    assign set_mode   = r_set_mode;
    assign blink      = r_blink;
    assign alarm_ring = r_ring;

endmodule

// File: doc/time_adjust_ctrl.md
TIME_ADJUST_CTRL -- requirements
Module: time_adjust_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_TICKS, default 30: number of idle tick_1hz pulses in a set state before returning to RUN (legal range 1..127).
REQ-002 SHALL have parameter ALARM_TICKS, default 60: number of tick_1hz pulses the alarm rings before auto-clearing (legal range 1..127).
REQ-003 SHALL have port clk, input, 1: system clock.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port tick_1hz, input, 1: one-cycle timebase pulse.
REQ-006 SHALL have ports btn_c, btn_l, btn_r, btn_u, btn_d, each input, 1: debounced one-cycle button pulses (center, left, right, up, down).
REQ-007 SHALL have ports sec_wrap and min_wrap, each input, 1: high when the seconds or minutes counter is at modulus-1.
REQ-008 SHALL have port alarm_match, input, 1: level, high while time equals alarm setting.
REQ-009 SHALL have ports sec_en, tmin_en, thr_en, amin_en and ahr_en, each output, 1: counter enables.
REQ-010 SHALL have port up_down, output, 1: counter direction (0 = up, 1 = down), shared by all counters.
REQ-011 SHALL have port sel, output, 2: field under adjustment (0 = time hour, 1 = time minute, 2 = alarm hour, 3 = alarm minute); 0 in RUN.
REQ-012 SHALL have port set_mode, output, 1: high in any set state.
REQ-013 SHALL have port blink, output, 1: display blink phase.
REQ-014 SHALL have port alarm_ring, output, 1: alarm active.

Function
REQ-015 States SHALL be RUN, SET_THR, SET_TMIN, SET_AHR and SET_AMIN.
REQ-016 Counter enables and up_down SHALL be combinational from the registered state and current inputs, giving zero latency.
REQ-017 In RUN: sec_en = tick_1hz; tmin_en = tick_1hz & sec_wrap; thr_en = tick_1hz & sec_wrap & min_wrap; up_down = 0; amin_en = ahr_en = 0.
REQ-018 In set states, timekeeping SHALL pause: sec_en = 0, and no cascade enables are produced.
REQ-019 A btn_c pulse in RUN SHALL move the state to SET_THR; a btn_c pulse in any set state SHALL move it to RUN; the transition takes effect next cycle.
REQ-020 In set states, btn_r SHALL advance the state SET_THR -> SET_TMIN -> SET_AHR -> SET_AMIN -> SET_THR, and btn_l SHALL step the same ring in reverse.
REQ-021 In a set state, btn_u SHALL assert the enable of the selected counter for exactly that cycle with up_down = 0; btn_d SHALL do the same with up_down = 1.
REQ-022 Button priority within a cycle SHALL be btn_c > (btn_l | btn_r) > (btn_u | btn_d).
REQ-023 btn_l and btn_r asserted together SHALL be ignored; btn_u and btn_d asserted together SHALL be ignored.
REQ-024 In RUN, btn_l, btn_r, btn_u and btn_d SHALL have no effect except clearing the alarm (REQ-029).
REQ-025 Timeout: a 7-bit idle counter SHALL clear on entry to a set state and on any button pulse, and increment on tick_1hz; when it reaches TIMEOUT_TICKS, the state SHALL go to RUN next cycle.
REQ-026 If a button pulse and a tick occur in the same cycle, the idle counter SHALL clear.
REQ-027 blink SHALL toggle on each tick_1hz while in a set state, and SHALL be forced to 0 in RUN and on every state entry.
REQ-028 Alarm start: alarm_ring SHALL set on a rising edge of alarm_match (registered previous value) while in RUN; a rising edge in a set state SHALL be ignored.
REQ-029 Alarm stop: alarm_ring SHALL clear on any button pulse, which is consumed with no other effect that cycle, or after ALARM_TICKS ticks counted by a dedicated 7-bit counter.
REQ-030 A btn_c press while ringing SHALL only silence the alarm and SHALL not enter a set state.
REQ-031 sel and set_mode SHALL be registered and decoded from the state.

Reset
REQ-032 On rst: state = RUN, idle and ring counters = 0, blink = 0, alarm_ring = 0, alarm_match history = 0, sel = 0, set_mode = 0.
REQ-033 While rst is asserted, all enables SHALL be 0.
REQ-034 Reset mid-adjustment SHALL abandon the set state immediately.

Verification
REQ-035 RUN, sec_wrap = min_wrap = 1, tick pulse -> sec_en = tmin_en = thr_en = 1 for that cycle only, up_down = 0.
REQ-036 btn_c, then btn_r twice, then btn_d -> state SET_AHR, sel = 2, ahr_en = 1 and up_down = 1 for one cycle, sec_en = 0 throughout.
REQ-037 In SET_TMIN, btn_u and btn_d together, then btn_c and btn_u together -> first cycle no enables; second cycle return to RUN with tmin_en = 0.
REQ-038 Enter SET_THR, apply 30 ticks with no buttons -> RUN on the cycle after the 30th tick; a button at tick 29 restarts the count.
REQ-039 alarm_match 0 -> 1 in RUN -> alarm_ring = 1 next cycle; 60 ticks later -> 0; repeat and press btn_c -> ring clears, state stays RUN.
REQ-040 Assert rst during SET_AMIN with blink = 1 -> state RUN, sel = 0, blink = 0, set_mode = 0 asynchronously.
